// File: rtl/baser_sched_pkg.sv
// Shared types and defaults for the 257b lane scheduler.
package baser_sched_pkg;
    typedef enum logic [1:0] {IDLE, ARB, HOLD} sched_state_t;

    localparam int TC_WIDTH_DEF    = 257;
    localparam int SLOT_CYCLES_DEF = 4;
    localparam int CNT_W           = 32;
endpackage

// File: rtl/baser_rr_arbiter.sv
// Round-robin arbiter: the first requester after the pointer wins, and the pointer then
// moves to that winner. It resets to the last lane, so lane 0 wins first.
module baser_rr_arbiter #(
    parameter int NUM_LANES = 4
) (
    input  logic                         clk,
    input  logic                         i_rst,
    input  logic [NUM_LANES-1:0]         i_req,
    input  logic                         i_advance,
    output logic [NUM_LANES-1:0]         o_gnt_onehot,
    output logic [$clog2(NUM_LANES)-1:0] o_gnt_idx
);
    localparam int LANE_W = $clog2(NUM_LANES);

    logic [LANE_W-1:0] ptr_q;
    logic [LANE_W-1:0] sel;
    int                idx;

    // Scan from the farthest lane back to the nearest one, so the nearest requester wins.
    always_comb begin
        o_gnt_onehot = '0;
        o_gnt_idx    = '0;
        idx          = 0;
        sel          = '0;
        for (int k = NUM_LANES; k >= 1; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            sel = LANE_W'(idx);
            if (i_req[sel]) begin
                o_gnt_onehot      = '0;
                o_gnt_onehot[sel] = 1'b1;
                o_gnt_idx         = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst)          ptr_q <= LANE_W'(NUM_LANES - 1);
        else if (i_advance) ptr_q <= o_gnt_idx;
    end
endmodule

// File: rtl/baser_257b_lane_scheduler.sv
// Shares one 257b checker chain between NUM_LANES sources, one block per SLOT_CYCLES clocks.
// Optional per-lane grant counters: define SCHED_LANE_STATS_EN.
module baser_257b_lane_scheduler
    import baser_sched_pkg::*;
#(
    parameter int TC_WIDTH    = TC_WIDTH_DEF,
    parameter int NUM_LANES   = 4,
    parameter int SLOT_CYCLES = SLOT_CYCLES_DEF,
    parameter int LANE_W      = $clog2(NUM_LANES)
) (
    input  logic                          clk,
    input  logic                          i_rst,
    input  logic                          i_enable,
    input  logic [NUM_LANES-1:0]          i_lane_mask,
    input  logic                          i_chk_busy,
    input  logic [NUM_LANES-1:0]          i_req_valid,
    input  logic [NUM_LANES*TC_WIDTH-1:0] i_req_data,
    output logic [NUM_LANES-1:0]          o_req_ready,
    output logic [TC_WIDTH-1:0]           o_xcoded,
    output logic                          o_xcoded_valid,
    output logic [LANE_W-1:0]             o_lane_id,
    output logic [$clog2(SLOT_CYCLES)-1:0] o_slot_phase,
    output logic [CNT_W-1:0]              o_grant_count,
    output logic [CNT_W-1:0]              o_idle_count,
    output logic [NUM_LANES*CNT_W-1:0]    o_lane_grant_count
);
    localparam int PH_W = $clog2(SLOT_CYCLES);

    sched_state_t                      state_q;
    logic [PH_W-1:0]                   phase_q;
    logic [TC_WIDTH-1:0]               xcoded_q;
    logic                              strobe_q;
    logic [LANE_W-1:0]                 lane_q;
    logic [CNT_W-1:0]                  grant_cnt_q;
    logic [CNT_W-1:0]                  idle_cnt_q;

    logic [NUM_LANES-1:0][TC_WIDTH-1:0] lane_data;
    logic [NUM_LANES-1:0]              eligible;
    logic [NUM_LANES-1:0]              arb_req;
    logic [NUM_LANES-1:0]              gnt_onehot;
    logic [LANE_W-1:0]                 gnt_idx;
    logic                              arb_slot;
    logic                              grant;

    assign lane_data = i_req_data;
    assign eligible  = i_req_valid & i_lane_mask;
    // Arbitration happens in ARB, and also in the last slot phase so that slots run back-to-back.
    assign arb_slot  = (state_q == ARB) ||
                       (state_q == HOLD && phase_q == PH_W'(SLOT_CYCLES - 1));
    assign arb_req   = (arb_slot && i_enable && !i_chk_busy && !i_rst) ? eligible : '0;
    assign grant     = |gnt_onehot;

    baser_rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_req        (arb_req),
        .i_advance    (grant),
        .o_gnt_onehot (gnt_onehot),
        .o_gnt_idx    (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            xcoded_q    <= '0;
            strobe_q    <= 1'b0;
            lane_q      <= '0;
            grant_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            strobe_q <= 1'b0;
            if (arb_slot && i_enable && eligible == '0 && idle_cnt_q != '1)
                idle_cnt_q <= idle_cnt_q + CNT_W'(1);
            if (grant) begin
                state_q     <= HOLD;
                phase_q     <= '0;
                xcoded_q    <= lane_data[gnt_idx];
                lane_q      <= gnt_idx;
                strobe_q    <= 1'b1;
                grant_cnt_q <= grant_cnt_q + CNT_W'(1);
            end else begin
                case (state_q)
                    IDLE: if (i_enable) state_q <= ARB;
                    ARB:  if (!i_enable) state_q <= IDLE;
                    HOLD: begin
                        if (arb_slot) begin
                            phase_q <= '0;
                            state_q <= i_enable ? ARB : IDLE;
                        end else begin
                            phase_q <= phase_q + PH_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_req_ready    = gnt_onehot;
    assign o_xcoded       = xcoded_q;
    assign o_xcoded_valid = strobe_q;
    assign o_lane_id      = lane_q;
    assign o_slot_phase   = phase_q;
    assign o_grant_count  = grant_cnt_q;
    assign o_idle_count   = idle_cnt_q;

`ifdef SCHED_LANE_STATS_EN
    logic [NUM_LANES-1:0][CNT_W-1:0] lane_cnt_q;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            lane_cnt_q <= '0;
        end else begin
            for (int n = 0; n < NUM_LANES; n++)
                if (gnt_onehot[n]) lane_cnt_q[n] <= lane_cnt_q[n] + CNT_W'(1);
        end
    end

    assign o_lane_grant_count = lane_cnt_q;
`else
    assign o_lane_grant_count = '0;
`endif
endmodule
